// File: rtl/nvdla_tb_scsv_credit_conv_if.sv
// Payload bundle between a valid/ready source and a valid/credit sink.
// master drives payloads and returns credits; slave is the convertor.
interface nvdla_tb_scsv_credit_conv_if #(
  parameter int PD_WIDTH = 514
);
  logic                in_valid;
  logic                in_ready;
  logic [PD_WIDTH-1:0] in_pd;
  logic                out_valid;
  logic [PD_WIDTH-1:0] out_pd;
  logic                credit_return;

  modport master (
    output in_valid, in_pd, credit_return,
    input  in_ready, out_valid, out_pd
  );

  modport slave (
    input  in_valid, in_pd, credit_return,
    output in_ready, out_valid, out_pd
  );
endinterface

// File: rtl/nvdla_tb_scsv_credit_conv.sv
// Valid/ready -> valid/credit convertor with DEPTH-entry buffer; RUN latency 2 cycles, BYPASS 1.
// Upstream stalls on a full buffer; downstream has no back-pressure, only credits.
module nvdla_tb_scsv_credit_conv #(
  parameter int PD_WIDTH   = 514,
  parameter int DEPTH      = 4,
  parameter int CREDIT_MAX = 64,
  parameter int CNT_W      = 7
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic [1:0]               cfg_mode,
  input  logic [CNT_W-1:0]         cfg_init_credit,
  input  logic                     cmod_credit_load,
  nvdla_tb_scsv_credit_conv_if.slave pd_if,
  output logic [CNT_W-1:0]         credit_cnt,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CMAX     = CNT_W'(CREDIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT_LOAD,
    ST_RUN,
    ST_BYPASS,
    ST_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [PD_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         occ;
  logic                full, empty, push, pop, rdy;
  logic [CNT_W-1:0]    init_clip;

  assign full      = (occ == OCC_FULL);
  assign empty     = (occ == '0);
  assign init_clip = (cfg_init_credit > CMAX) ? CMAX : cfg_init_credit;
  assign pd_if.in_ready = rdy;

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_INIT: begin
        case (cfg_mode)
          2'b00:   state_d = ST_RUN;
          2'b01:   state_d = ST_WAIT_LOAD;
          2'b10:   state_d = ST_BYPASS;
          default: state_d = ST_HOLD;
        endcase
      end
      ST_WAIT_LOAD: begin
        rdy  = !full;
        push = rdy && pd_if.in_valid;
        if (cmod_credit_load) state_d = ST_RUN;
      end
      ST_RUN: begin
        // ready comes from the registered count, so a same-cycle pop never frees a slot
        rdy  = !full;
        push = rdy && pd_if.in_valid;
        pop  = !empty && (credit_cnt != '0);
      end
      ST_BYPASS: rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem[wr_ptr] <= pd_if.in_pd;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q         <= ST_INIT;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      pd_if.out_valid <= 1'b0;
      pd_if.out_pd    <= '0;
      credit_cnt      <= '0;
      ovf_err         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pd_if.out_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: ;
      endcase
      case (state_q)
        ST_INIT: begin
          if (cfg_mode == 2'b00) credit_cnt <= init_clip;
        end
        ST_WAIT_LOAD: begin
          // credits cannot be returned before any were granted
          if (pd_if.credit_return) ovf_err <= 1'b1;
          if (cmod_credit_load)    credit_cnt <= init_clip;
        end
        ST_RUN: begin
          pd_if.out_valid <= pop;
          if (pop) pd_if.out_pd <= mem[rd_ptr];
          if (pop && !pd_if.credit_return) begin
            credit_cnt <= credit_cnt - CNT_ONE;
          end else if (pd_if.credit_return && !pop) begin
            if (credit_cnt == CMAX) ovf_err    <= 1'b1;
            else                    credit_cnt <= credit_cnt + CNT_ONE;
          end
        end
        ST_BYPASS: begin
          pd_if.out_valid <= pd_if.in_valid;
          if (pd_if.in_valid) pd_if.out_pd <= pd_if.in_pd;
          credit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_tb_scsv_credit_conv.sv
// Directed bench for the credit convertor: RUN, GATING, full buffer, overflow, BYPASS, HOLD, reset.
module tb_nvdla_tb_scsv_credit_conv;
  localparam int PDW   = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [1:0]       cfg_mode = 2'b00;
  logic [CNT_W-1:0] cfg_init_credit = '0;
  logic             cmod_credit_load = 1'b0;
  logic [CNT_W-1:0] credit_cnt;
  logic             ovf_err;

  int n_checks = 0;
  int n_errors = 0;

  nvdla_tb_scsv_credit_conv_if #(.PD_WIDTH(PDW)) pd_if();

  nvdla_tb_scsv_credit_conv #(
    .PD_WIDTH(PDW), .DEPTH(DEPTH), .CREDIT_MAX(64), .CNT_W(CNT_W)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .cfg_mode        (cfg_mode),
    .cfg_init_credit (cfg_init_credit),
    .cmod_credit_load(cmod_credit_load),
    .pd_if           (pd_if.slave),
    .credit_cnt      (credit_cnt),
    .ovf_err         (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic [CNT_W-1:0] init);
    rstn = 1'b0;
    pd_if.in_valid = 1'b0;
    pd_if.in_pd = '0;
    pd_if.credit_return = 1'b0;
    cmod_credit_load = 1'b0;
    cfg_mode = mode;
    cfg_init_credit = init;
    step();
    step();
    rstn = 1'b1;
  endtask

  logic [PDW-1:0] beats [5];
  logic [PDW-1:0] exp_pd;
  logic           exp_vld;
  int             cnt;

  initial begin
    beats[0] = 32'hA000_000A;
    beats[1] = 32'hB000_000B;
    beats[2] = 32'hC000_000C;
    beats[3] = 32'hD000_000D;
    beats[4] = 32'hE000_000E;

    // 1: RUN, two initial credits
    do_reset(2'b00, 7'd2);
    chk("rst_out_valid", 64'(pd_if.out_valid), 64'd0);
    chk("rst_in_ready",  64'(pd_if.in_ready),  64'd0);
    chk("rst_credit",    64'(credit_cnt),      64'd0);
    chk("rst_ovf",       64'(ovf_err),         64'd0);
    chk("rst_out_pd",    64'(pd_if.out_pd),    64'd0);
    step();
    chk("t1_init_credit", 64'(credit_cnt), 64'd2);
    for (int i = 0; i < 6; i++) begin
      pd_if.in_valid = (i < 4);
      pd_if.in_pd    = beats[i % 4];
      step();
      exp_vld = (i == 1) || (i == 2);
      chk("t1_out_valid", 64'(pd_if.out_valid), 64'(exp_vld));
      if (exp_vld) chk("t1_out_pd", 64'(pd_if.out_pd), 64'(beats[i - 1]));
    end
    pd_if.in_valid = 1'b0;
    chk("t1_credit_zero", 64'(credit_cnt), 64'd0);
    chk("t1_in_ready",    64'(pd_if.in_ready), 64'd1);
    pd_if.credit_return = 1'b1;
    step();
    pd_if.credit_return = 1'b0;
    chk("t1_ret_no_out", 64'(pd_if.out_valid), 64'd0);
    chk("t1_ret_credit", 64'(credit_cnt), 64'd1);
    step();
    chk("t1_c_valid", 64'(pd_if.out_valid), 64'd1);
    chk("t1_c_pd",    64'(pd_if.out_pd), 64'(beats[2]));
    step();
    chk("t1_hold_valid", 64'(pd_if.out_valid), 64'd0);
    chk("t1_hold_pd",    64'(pd_if.out_pd), 64'(beats[2]));

    // 2: GATING, payloads wait for the load pulse
    do_reset(2'b01, 7'd3);
    step();
    for (int i = 0; i < 2; i++) begin
      pd_if.in_valid = 1'b1;
      pd_if.in_pd    = beats[i];
      step();
    end
    pd_if.in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pd_if.out_valid) cnt++;
    end
    chk("t2_gated", 64'(cnt), 64'd0);
    chk("t2_gated_credit", 64'(credit_cnt), 64'd0);
    cmod_credit_load = 1'b1;
    step();
    cmod_credit_load = 1'b0;
    chk("t2_load_credit", 64'(credit_cnt), 64'd3);
    step();
    chk("t2_b0_valid", 64'(pd_if.out_valid), 64'd1);
    chk("t2_b0_pd",    64'(pd_if.out_pd), 64'(beats[0]));
    step();
    chk("t2_b1_valid", 64'(pd_if.out_valid), 64'd1);
    chk("t2_b1_pd",    64'(pd_if.out_pd), 64'(beats[1]));
    step();
    chk("t2_end_valid", 64'(pd_if.out_valid), 64'd0);
    chk("t2_end_credit", 64'(credit_cnt), 64'd1);
    chk("t2_ovf", 64'(ovf_err), 64'd0);

    // 3: no credit, fill the buffer and overflow the source by one
    do_reset(2'b00, 7'd0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_ready_fill", 64'(pd_if.in_ready), 64'd1);
      pd_if.in_valid = 1'b1;
      pd_if.in_pd    = beats[i];
      step();
    end
    chk("t3_full_ready", 64'(pd_if.in_ready), 64'd0);
    pd_if.in_pd = beats[4];
    step();
    step();
    chk("t3_still_full", 64'(pd_if.in_ready), 64'd0);
    chk("t3_no_out",     64'(pd_if.out_valid), 64'd0);
    pd_if.credit_return = 1'b1;
    step();
    pd_if.credit_return = 1'b0;
    chk("t3_ret_ready", 64'(pd_if.in_ready), 64'd0);
    step();
    chk("t3_pop_valid", 64'(pd_if.out_valid), 64'd1);
    chk("t3_pop_pd",    64'(pd_if.out_pd), 64'(beats[0]));
    chk("t3_pop_ready", 64'(pd_if.in_ready), 64'd1);
    step();
    pd_if.in_valid = 1'b0;
    chk("t3_e_taken", 64'(pd_if.in_ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      pd_if.credit_return = (i < 4);
      step();
      exp_vld = (i >= 1) && (i <= 4);
      chk("t3_drain_valid", 64'(pd_if.out_valid), 64'(exp_vld));
      if (exp_vld) chk("t3_drain_pd", 64'(pd_if.out_pd), 64'(beats[i]));
    end
    chk("t3_end_credit", 64'(credit_cnt), 64'd0);

    // 4: credit at max, a return is an overflow
    do_reset(2'b00, 7'd64);
    step();
    chk("t4_credit_max", 64'(credit_cnt), 64'd64);
    chk("t4_ovf_clear",  64'(ovf_err), 64'd0);
    pd_if.credit_return = 1'b1;
    step();
    pd_if.credit_return = 1'b0;
    chk("t4_credit_hold", 64'(credit_cnt), 64'd64);
    chk("t4_ovf_set",     64'(ovf_err), 64'd1);
    step();
    step();
    chk("t4_ovf_sticky", 64'(ovf_err), 64'd1);
    do_reset(2'b00, 7'd100);
    step();
    chk("t4_clip", 64'(credit_cnt), 64'd64);

    // 5: BYPASS, one-cycle passthrough, credits ignored
    do_reset(2'b10, 7'd5);
    step();
    exp_pd = '0;
    for (int i = 0; i < 16; i++) begin
      exp_vld = 1'($urandom_range(0, 1));
      pd_if.in_valid = exp_vld;
      pd_if.in_pd = $urandom;
      pd_if.credit_return = 1'($urandom_range(0, 1));
      if (exp_vld) exp_pd = pd_if.in_pd;
      step();
      chk("t5_valid", 64'(pd_if.out_valid), 64'(exp_vld));
      chk("t5_pd",    64'(pd_if.out_pd), 64'(exp_pd));
    end
    chk("t5_ready",  64'(pd_if.in_ready), 64'd1);
    chk("t5_credit", 64'(credit_cnt), 64'd0);
    pd_if.in_valid = 1'b0;
    pd_if.credit_return = 1'b0;

    // 6: HOLD ignores everything
    do_reset(2'b11, 7'd5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pd_if.in_valid = 1'b1;
      pd_if.in_pd = beats[i % 5];
      pd_if.credit_return = i[0];
      cmod_credit_load = 1'b1;
      step();
      if (pd_if.in_ready || pd_if.out_valid) cnt++;
    end
    chk("t6_hold_quiet",  64'(cnt), 64'd0);
    chk("t6_hold_credit", 64'(credit_cnt), 64'd0);

    // 6b: reset while RUN holds three beats
    do_reset(2'b00, 7'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      pd_if.in_valid = 1'b1;
      pd_if.in_pd = beats[i];
      step();
    end
    pd_if.in_valid = 1'b0;
    step();
    chk("t6_pre_pd", 64'(pd_if.out_pd), 64'(beats[0]));
    rstn = 1'b0;
    step();
    chk("t6_rst_valid",  64'(pd_if.out_valid), 64'd0);
    chk("t6_rst_ready",  64'(pd_if.in_ready), 64'd0);
    chk("t6_rst_pd",     64'(pd_if.out_pd), 64'd0);
    chk("t6_rst_credit", 64'(credit_cnt), 64'd0);
    cfg_init_credit = 7'd5;
    rstn = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pd_if.out_valid) cnt++;
    end
    chk("t6_dropped", 64'(cnt), 64'd0);
    chk("t6_credit_after", 64'(credit_cnt), 64'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
